// File: rtl/pipe_hazard_sched_if.sv
// Pipeline-side view of the hazard scheduler: D/E-stage decode flags in,
// stall/flush controls and the stall counter out.
interface pipe_hazard_sched_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic             D_useRs;
  logic             D_useRt;
  logic             D_useMD;
  logic             E_isLoad;
  logic [4:0]       E_wa;
  logic             E_mdStart;
  logic             E_isDiv;
  logic             exc_req;
  logic             PC_WE;
  logic             IFID_WE;
  logic             IFID_clr;
  logic             IDEX_clr;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_useRs, D_useRt, D_useMD,
    output E_isLoad, E_wa, E_mdStart, E_isDiv, exc_req,
    input  PC_WE, IFID_WE, IFID_clr, IDEX_clr, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_useRs, D_useRt, D_useMD,
    input  E_isLoad, E_wa, E_mdStart, E_isDiv, exc_req,
    output PC_WE, IFID_WE, IFID_clr, IDEX_clr, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Stall/flush scheduler for the five-stage pipeline: load-use and HI/LO
// occupancy hazards, mult/div busy sequencer and a stall-cycle counter.
module pipe_hazard_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_sched_if.slave bus
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e            state_r;
  logic [LAT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic md_busy_s;
  logic ld_hz_s;
  logic md_hz_s;
  logic stall_s;

  // Hazard detection; $0 never carries a real dependency.
  always_comb begin
    md_busy_s = bus.E_mdStart | (state_r != IDLE);
    ld_hz_s   = bus.E_isLoad & (bus.E_wa != 5'd0) &
                ((bus.D_useRs & (bus.D_rs == bus.E_wa)) |
                 (bus.D_useRt & (bus.D_rt == bus.E_wa)));
    md_hz_s   = bus.D_useMD & md_busy_s;
    stall_s   = ld_hz_s | md_hz_s;
  end

  // Pipeline control: redirect beats stall, stall beats normal flow.
  always_comb begin
    bus.PC_WE    = 1'b1;
    bus.IFID_WE  = 1'b1;
    bus.IFID_clr = 1'b0;
    bus.IDEX_clr = 1'b0;
    if (bus.exc_req) begin
      bus.PC_WE    = 1'b1;
      bus.IFID_WE  = 1'b1;
      bus.IFID_clr = 1'b1;
      bus.IDEX_clr = 1'b1;
    end else if (stall_s) begin
      bus.PC_WE    = 1'b0;
      bus.IFID_WE  = 1'b0;
      bus.IFID_clr = 1'b0;
      bus.IDEX_clr = 1'b1;
    end else begin
      bus.PC_WE    = 1'b1;
      bus.IFID_WE  = 1'b1;
      bus.IFID_clr = 1'b0;
      bus.IDEX_clr = 1'b0;
    end
  end

  assign bus.md_busy   = md_busy_s;
  assign bus.stall_cnt = stall_cnt_r;

  // Mult/div busy sequencer; a redirect does not cancel HI/LO work.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.E_mdStart) begin
            if (bus.E_isDiv) begin
              state_r <= DIV;
              cnt_r   <= LAT_W'(DIV_LAT - 1);
            end else begin
              state_r <= MULT;
              cnt_r   <= LAT_W'(MULT_LAT - 1);
            end
          end else begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end
        end
        MULT, DIV: begin
          if (cnt_r == '0) begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r - LAT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Stall performance counter; wraps freely.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= '0;
    end else if (stall_s && !bus.exc_req) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed bench for pipe_hazard_sched; a second 4-bit-counter instance
// shares the stimulus to exercise counter wrap.
module tb_pipe_hazard_sched;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_cnt;
  int   busy_n;
  int   stall_n;

  pipe_hazard_sched_if #(.CNT_W(32)) ifc ();
  pipe_hazard_sched_if #(.CNT_W(4))  ifc4 ();

  assign ifc4.D_rs      = ifc.D_rs;
  assign ifc4.D_rt      = ifc.D_rt;
  assign ifc4.D_useRs   = ifc.D_useRs;
  assign ifc4.D_useRt   = ifc.D_useRt;
  assign ifc4.D_useMD   = ifc.D_useMD;
  assign ifc4.E_isLoad  = ifc.E_isLoad;
  assign ifc4.E_wa      = ifc.E_wa;
  assign ifc4.E_mdStart = ifc.E_mdStart;
  assign ifc4.E_isDiv   = ifc.E_isDiv;
  assign ifc4.exc_req   = ifc.exc_req;

  pipe_hazard_sched #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  pipe_hazard_sched #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifc.D_rs      = 5'd0;
    ifc.D_rt      = 5'd0;
    ifc.D_useRs   = 1'b0;
    ifc.D_useRt   = 1'b0;
    ifc.D_useMD   = 1'b0;
    ifc.E_isLoad  = 1'b0;
    ifc.E_wa      = 5'd0;
    ifc.E_mdStart = 1'b0;
    ifc.E_isDiv   = 1'b0;
    ifc.exc_req   = 1'b0;
  endtask

  // Pulse a mult/div start and count busy and stalled cycles over a window.
  task automatic run_md(input logic is_div, input logic use_md, input int exc_at,
                        output int busy_o, output int stall_o);
    busy_o = 0;
    stall_o = 0;
    ifc.E_mdStart = 1'b1;
    ifc.E_isDiv   = is_div;
    ifc.D_useMD   = use_md;
    for (int i = 0; i < 20; i++) begin
      ifc.exc_req = (i == exc_at);
      #1;
      busy_o  += int'(ifc.md_busy);
      stall_o += int'(!ifc.PC_WE);
      tick();
      ifc.E_mdStart = 1'b0;
      ifc.E_isDiv   = 1'b0;
    end
    ifc.exc_req = 1'b0;
    ifc.D_useMD = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    clear_in();
    reset = 1'b0;
    tick();
    tick();

    // Reset state, and reset beating a simultaneous start
    chk("rst_pc_we",    32'(ifc.PC_WE), 32'd1);
    chk("rst_ifid_we",  32'(ifc.IFID_WE), 32'd1);
    chk("rst_ifid_clr", 32'(ifc.IFID_clr), 32'd0);
    chk("rst_idex_clr", 32'(ifc.IDEX_clr), 32'd0);
    chk("rst_stall_cnt", ifc.stall_cnt, 32'd0);
    ifc.E_mdStart = 1'b1;
    #1;
    chk("rst_busy_follows_start", 32'(ifc.md_busy), 32'd1);
    tick();
    ifc.E_mdStart = 1'b0;
    #1;
    chk("rst_start_ignored", 32'(ifc.md_busy), 32'd0);
    reset = 1'b1;
    tick();

    // Load-use on rs
    ifc.E_isLoad = 1'b1; ifc.E_wa = 5'd8; ifc.D_useRs = 1'b1; ifc.D_rs = 5'd8;
    #1;
    chk("ld_rs_pc_we",    32'(ifc.PC_WE), 32'd0);
    chk("ld_rs_ifid_we",  32'(ifc.IFID_WE), 32'd0);
    chk("ld_rs_ifid_clr", 32'(ifc.IFID_clr), 32'd0);
    chk("ld_rs_idex_clr", 32'(ifc.IDEX_clr), 32'd1);
    tick();
    exp_cnt = 1;
    clear_in();
    #1;
    chk("ld_rs_cnt", ifc.stall_cnt, 32'(exp_cnt));
    chk("ld_rs_released", 32'(ifc.PC_WE), 32'd1);

    // Load to $0 never stalls
    ifc.E_isLoad = 1'b1; ifc.E_wa = 5'd0; ifc.D_useRs = 1'b1; ifc.D_rs = 5'd0;
    #1;
    chk("ld_r0_pc_we",    32'(ifc.PC_WE), 32'd1);
    chk("ld_r0_idex_clr", 32'(ifc.IDEX_clr), 32'd0);
    tick();
    chk("ld_r0_cnt", ifc.stall_cnt, 32'(exp_cnt));

    // Load-use on rt, then a non-matching rt
    clear_in();
    ifc.E_isLoad = 1'b1; ifc.E_wa = 5'd17; ifc.D_useRt = 1'b1; ifc.D_rt = 5'd17;
    #1;
    chk("ld_rt_pc_we", 32'(ifc.PC_WE), 32'd0);
    tick();
    exp_cnt++;
    ifc.D_rt = 5'd9;
    #1;
    chk("ld_rt_nomatch", 32'(ifc.PC_WE), 32'd1);
    ifc.D_rt = 5'd17; ifc.D_useRt = 1'b0;
    #1;
    chk("ld_rt_unused", 32'(ifc.PC_WE), 32'd1);
    chk("ld_rt_cnt", ifc.stall_cnt, 32'(exp_cnt));
    clear_in();
    tick();

    // Mult occupancy with dependent HI/LO reader
    run_md(1'b0, 1'b1, -1, busy_n, stall_n);
    exp_cnt += 6;
    chk("mult_busy_cycles", 32'(busy_n), 32'd6);
    chk("mult_stall_cycles", 32'(stall_n), 32'd6);
    chk("mult_pc_we_after", 32'(ifc.PC_WE), 32'd1);
    chk("mult_cnt", ifc.stall_cnt, 32'(exp_cnt));

    // Independent instruction during mult
    run_md(1'b0, 1'b0, -1, busy_n, stall_n);
    chk("mult_indep_busy", 32'(busy_n), 32'd6);
    chk("mult_indep_stall", 32'(stall_n), 32'd0);

    // Div occupancy
    run_md(1'b1, 1'b1, -1, busy_n, stall_n);
    exp_cnt += 11;
    chk("div_busy_cycles", 32'(busy_n), 32'd11);
    chk("div_stall_cycles", 32'(stall_n), 32'd11);
    chk("div_cnt", ifc.stall_cnt, 32'(exp_cnt));

    // Redirect mid-mult keeps the unit counting
    run_md(1'b0, 1'b0, 2, busy_n, stall_n);
    chk("mult_exc_busy", 32'(busy_n), 32'd6);

    // Exception overrides a load-use stall
    ifc.E_isLoad = 1'b1; ifc.E_wa = 5'd8; ifc.D_useRs = 1'b1; ifc.D_rs = 5'd8;
    ifc.exc_req = 1'b1;
    #1;
    chk("exc_pc_we",    32'(ifc.PC_WE), 32'd1);
    chk("exc_ifid_we",  32'(ifc.IFID_WE), 32'd1);
    chk("exc_ifid_clr", 32'(ifc.IFID_clr), 32'd1);
    chk("exc_idex_clr", 32'(ifc.IDEX_clr), 32'd1);
    tick();
    clear_in();
    #1;
    chk("exc_cnt_held", ifc.stall_cnt, 32'(exp_cnt));

    // Reset three cycles into a div
    ifc.E_mdStart = 1'b1; ifc.E_isDiv = 1'b1; ifc.D_useMD = 1'b1;
    tick();
    ifc.E_mdStart = 1'b0; ifc.E_isDiv = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ifc.D_useMD = 1'b0;
    #1;
    chk("rst_div_busy", 32'(ifc.md_busy), 32'd0);
    chk("rst_div_cnt", ifc.stall_cnt, 32'd0);
    run_md(1'b0, 1'b1, -1, busy_n, stall_n);
    chk("post_rst_mult_busy", 32'(busy_n), 32'd6);
    chk("post_rst_cnt", ifc.stall_cnt, 32'd6);

    // Counter wrap on the 4-bit instance
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ifc.E_isLoad = 1'b1; ifc.E_wa = 5'd3; ifc.D_useRs = 1'b1; ifc.D_rs = 5'd3;
    for (int i = 0; i < 17; i++) tick();
    clear_in();
    #1;
    chk("wrap_cnt4", 32'(ifc4.stall_cnt), 32'd1);
    chk("wrap_cnt32", ifc.stall_cnt, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
- Stall/flush scheduler for the five-stage pipeline. It drives the PC write enable, the IF/ID write enable and flush, and the ID/EX flush.
- It resolves load-use hazards and HI/LO-unit occupancy.
- It owns a multi-cycle mult/div busy sequencer and a stall-cycle performance counter.
- It sits beside the IF/ID register and consumes D-stage decode flags and E-stage status.

Parameters:
MULT_LAT, 5, busy cycles after a mult/multu start
DIV_LAT, 10, busy cycles after a div/divu start
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
D_rs  in  5  rs field of the D-stage instruction
D_rt  in  5  rt field of the D-stage instruction
D_useRs  in  1  D-stage instruction reads rs in D (branch/jr compare)
D_useRt  in  1  D-stage instruction reads rt in D
D_useMD  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
E_isLoad  in  1  E-stage instruction is lb/lbu/lh/lhu/lw
E_wa  in  5  E-stage destination register
E_mdStart  in  1  E-stage instruction starts the mult/div unit this cycle
E_isDiv  in  1  qualifies E_mdStart: 1 = div/divu, 0 = mult/multu
exc_req  in  1  exception, interrupt or eret redirect taken this cycle
PC_WE  out  1  PC update enable
IFID_WE  out  1  IF/ID write enable
IFID_clr  out  1  IF/ID flush (write of a nop)
IDEX_clr  out  1  ID/EX flush (bubble insert)
md_busy  out  1  mult/div unit occupied (start or counting)
stall_cnt  out  CNT_W  total stall cycles since reset

Behaviour:
- Reset: with reset=0 at a clk edge, state<=IDLE, busy counter<=0 and stall_cnt<=0.
  - Reset wins over any simultaneous E_mdStart or exc_req.
  - A reset during a mult/div operation aborts it; md_busy is 0 from the next cycle.
  - All outputs are combinational from state and inputs. Values while reset=0 and after it: PC_WE=1, IFID_WE=1, IFID_clr=0, IDEX_clr=0, md_busy=E_mdStart, stall_cnt=0.
- Busy sequencer FSM: IDLE, MULT and DIV.
  - In IDLE, E_mdStart=1 loads cnt=MULT_LAT-1 and goes to MULT; with E_isDiv=1 it loads DIV_LAT-1 and goes to DIV.
  - In MULT/DIV the counter decrements each cycle. When cnt==0 at an edge, the FSM returns to IDLE.
  - A start cycle followed by MULT_LAT (or DIV_LAT) busy cycles gives exactly LAT+1 cycles of md_busy=1.
  - E_mdStart while not IDLE cannot occur, because the D-stage stall prevents it. If it does occur, it is ignored and the verifier flags it by assertion.
  - md_busy = E_mdStart | (state!=IDLE).
- Hazard terms (combinational, same cycle):
  - ld_hz = E_isLoad & E_wa!=0 & ((D_useRs & D_rs==E_wa) | (D_useRt & D_rt==E_wa)).
  - md_hz = D_useMD & md_busy.
  - stall = ld_hz | md_hz.
- Priority, highest first:
  - exc_req=1: PC_WE=1, IFID_WE=1, IFID_clr=1, IDEX_clr=1. Any stall is overridden, and the busy FSM keeps counting; HI/LO work is not cancelled.
  - stall=1: PC_WE=0, IFID_WE=0, IFID_clr=0, IDEX_clr=1.
  - Otherwise: PC_WE=1, IFID_WE=1, both clears 0.
- stall_cnt increments by 1 at each edge where stall=1 and exc_req=0 and reset=1. It wraps modulo 2^CNT_W with no saturation.
- Register $0 never causes a load-use stall.

Test Plan:
1. Load-use hazard: E_isLoad=1, E_wa=8, D_useRs=1, D_rs=8.
   - Required: PC_WE=0, IFID_WE=0, IDEX_clr=1 for one cycle, and stall_cnt goes 0->1.
   - Repeat with E_wa=0: no stall.
2. Mult occupancy: pulse E_mdStart=1, E_isDiv=0, then hold D_useMD=1.
   - Required: md_busy high for 6 cycles, stall for 6 cycles, then PC_WE=1.
   - With E_isDiv=1: md_busy high for 11 cycles.
3. Independent instruction during mult: after the mult start, D_useMD=0 with no load hazard.
   - Required: no stall while md_busy=1.
4. Exception during a stall: ld_hz active and exc_req=1.
   - Required: PC_WE=1, IFID_WE=1, IFID_clr=1, IDEX_clr=1, and stall_cnt does not increment.
5. Reset during an operation: reset=0 three cycles into a div.
   - Required: md_busy=0 and stall_cnt=0 on the following cycle, and a subsequent mult gives a 6-cycle busy window.
6. Counter wrap: with CNT_W=4, hold a stall for 17 cycles.
   - Required: stall_cnt reads 1.
